// File: rtl/pipeline_stall_controller_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// pipeline_ctrl_pkg : shared stall-controller types and constants
// Rev 1.0
// ------------------------------------------------------------------
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ctrl_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          CNT_W     = 6;

  // Counter must hold max(MUL,DIV)-2; never narrower than CNT_W.
  function automatic int cnt_width(input int mul_c, input int div_c);
    int mx;
    int w;
    mx = ((mul_c > div_c) ? mul_c : div_c) - 2;
    w  = $clog2(mx + 1);
    return (w > CNT_W) ? w : CNT_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_stall_controller_if.sv
`default_nettype none
// ------------------------------------------------------------------
// pipeline_stall_controller_if : hazard inputs and stage-enable outputs
// Rev 1.0
// ------------------------------------------------------------------
interface pipeline_stall_controller_if;
  logic        mem_wait;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        exe_is_load;
  logic        exe_GPR_we;
  logic [4:0]  exe_GPR_waddr;
  logic        exe_muldiv_start;
  logic        exe_muldiv_is_div;
  logic        pc_ena;
  logic        if_id_ena;
  logic        id_exe_ena;
  logic        exe_mem_ena;
  logic        mem_wb_ena;
  logic        id_exe_bubble;
  logic        exe_mem_bubble;
  logic        muldiv_busy;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cycles;

  modport master (
    output mem_wait, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
           exe_is_load, exe_GPR_we, exe_GPR_waddr, exe_muldiv_start, exe_muldiv_is_div,
    input  pc_ena, if_id_ena, id_exe_ena, exe_mem_ena, mem_wb_ena,
           id_exe_bubble, exe_mem_bubble, muldiv_busy, ctrl_state, stall_cycles
  );

  modport slave (
    input  mem_wait, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
           exe_is_load, exe_GPR_we, exe_GPR_waddr, exe_muldiv_start, exe_muldiv_is_div,
    output pc_ena, if_id_ena, id_exe_ena, exe_mem_ena, mem_wb_ena,
           id_exe_bubble, exe_mem_bubble, muldiv_busy, ctrl_state, stall_cycles
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_stall_controller_load_use_detect.sv
`default_nettype none
// ------------------------------------------------------------------
// load_use_detect : flags an ID source register produced by a load in EXE
// Rev 1.0
// ------------------------------------------------------------------
module load_use_detect (
  input  wire logic       exe_is_load,
  input  wire logic       exe_gpr_we,
  input  wire logic [4:0] exe_gpr_waddr,
  input  wire logic [4:0] id_rs_addr,
  input  wire logic [4:0] id_rt_addr,
  input  wire logic       id_uses_rs,
  input  wire logic       id_uses_rt,
  output logic            hazard
);
  logic rs_hit;
  logic rt_hit;

  // $zero is never a real dependency.
  assign rs_hit = id_uses_rs && (id_rs_addr == exe_gpr_waddr);
  assign rt_hit = id_uses_rt && (id_rt_addr == exe_gpr_waddr);
  assign hazard = exe_is_load && exe_gpr_we && (exe_gpr_waddr != 5'd0) && (rs_hit || rt_hit);
endmodule
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ------------------------------------------------------------------
// pipeline_stall_controller : per-stage enables/bubbles for mem wait, muldiv, load-use
// Rev 1.0
// ------------------------------------------------------------------
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  wire logic                    clk,
  input  wire logic                    reset,
  pipeline_stall_controller_if.slave   ctrl
);
  localparam int            CW       = cnt_width(MUL_CYCLES, DIV_CYCLES);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 2);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 2);

  ctrl_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   stall_cycles_q, stall_cycles_d;
  logic          hazard;
  logic [4:0]    ena;
  logic [1:0]    bub;

  load_use_detect u_load_use_detect (
    .exe_is_load   (ctrl.exe_is_load),
    .exe_gpr_we    (ctrl.exe_GPR_we),
    .exe_gpr_waddr (ctrl.exe_GPR_waddr),
    .id_rs_addr    (ctrl.id_rs_addr),
    .id_rt_addr    (ctrl.id_rt_addr),
    .id_uses_rs    (ctrl.id_uses_rs),
    .id_uses_rt    (ctrl.id_uses_rt),
    .hazard        (hazard)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // ena = {pc, if_id, id_exe, exe_mem, mem_wb}; bub = {id_exe, exe_mem}
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ena     = 5'b11111;
    bub     = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (ctrl.exe_muldiv_start) begin
          ena = 5'b00011;
          bub = 2'b01;
          if (!ctrl.mem_wait) begin
            state_d = ST_BUSY;
            cnt_d   = ctrl.exe_muldiv_is_div ? DIV_LOAD : MUL_LOAD;
          end
        end else if (hazard) begin
          ena = 5'b00111;
          bub = 2'b10;
        end
      end
      ST_BUSY: begin
        ena = 5'b00011;
        bub = 2'b01;
        // The unit keeps computing through a memory wait.
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_DONE: begin
        if (!ctrl.mem_wait) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!reset || ctrl.mem_wait) begin
      ena = 5'b00000;
      bub = 2'b00;
    end

    stall_cycles_d = stall_cycles_q + {31'd0, ~ena[4]};
  end

  assign ctrl.pc_ena         = ena[4];
  assign ctrl.if_id_ena      = ena[3];
  assign ctrl.id_exe_ena     = ena[2];
  assign ctrl.exe_mem_ena    = ena[1];
  assign ctrl.mem_wb_ena     = ena[0];
  assign ctrl.id_exe_bubble  = bub[1];
  assign ctrl.exe_mem_bubble = bub[0];
  assign ctrl.muldiv_busy    = (state_q != ST_IDLE);
  assign ctrl.ctrl_state     = state_q;
  assign ctrl.stall_cycles   = stall_cycles_q;
endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_pipeline_stall_controller : scoreboard bench, directed + random stimulus
// Rev 1.0
// ------------------------------------------------------------------
module tb_pipeline_stall_controller;
  localparam int MUL_C = 4;
  localparam int DIV_C = 32;

  typedef struct packed {
    logic       rst_n;
    logic       mw;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       ld;
    logic       we;
    logic [4:0] wa;
    logic       st;
    logic       dv;
  } stim_t;

  typedef struct {
    logic [4:0]  ena;
    logic [1:0]  bub;
    logic [1:0]  st;
    logic        busy;
    logic [31:0] sc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  // Reference: remaining BUSY cycles, pending DONE flag, stall total
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_sc   = 32'd0;

  pipeline_stall_controller_if sif ();

  pipeline_stall_controller #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .clk   (clk),
    .reset (rst_n),
    .ctrl  (sif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s       = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s, input bit preload);
    exp_t e;
    bit   hz;
    @(posedge clk);
    #1;
    if (preload) begin
      force dut.stall_cycles_q = 32'hFFFF_FFFF;
      m_sc = 32'hFFFF_FFFF;
    end
    rst_n                 = s.rst_n;
    sif.mem_wait          = s.mw;
    sif.id_rs_addr        = s.rs;
    sif.id_rt_addr        = s.rt;
    sif.id_uses_rs        = s.urs;
    sif.id_uses_rt        = s.urt;
    sif.exe_is_load       = s.ld;
    sif.exe_GPR_we        = s.we;
    sif.exe_GPR_waddr     = s.wa;
    sif.exe_muldiv_start  = s.st;
    sif.exe_muldiv_is_div = s.dv;

    e.sc   = m_sc;
    e.st   = (m_left > 0) ? 2'd1 : (m_done ? 2'd2 : 2'd0);
    e.busy = (e.st != 2'd0);
    hz = s.ld && s.we && (s.wa != 5'd0) &&
         ((s.urs && s.rs == s.wa) || (s.urt && s.rt == s.wa));
    if (!s.rst_n) begin
      e.ena = 5'b00000; e.bub = 2'b00;
      m_left = 0; m_done = 1'b0; m_sc = 32'd0;
    end else begin
      if (s.mw) begin
        e.ena = 5'b00000; e.bub = 2'b00;
      end else if (m_left > 0 || (!m_done && s.st)) begin
        e.ena = 5'b00011; e.bub = 2'b01;
      end else if (!m_done && hz) begin
        e.ena = 5'b00111; e.bub = 2'b10;
      end else begin
        e.ena = 5'b11111; e.bub = 2'b00;
      end
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end else if (m_done) begin
        if (!s.mw) m_done = 1'b0;
      end else if (s.st && !s.mw) begin
        m_left = (s.dv ? DIV_C : MUL_C) - 1;
      end
      if (!e.ena[4]) m_sc = m_sc + 32'd1;
    end
    q.push_back(e);
    if (preload) begin
      #1;
      release dut.stall_cycles_q;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("enables", {27'd0, sif.pc_ena, sif.if_id_ena, sif.id_exe_ena, sif.exe_mem_ena,
                      sif.mem_wb_ena}, {27'd0, e.ena});
      chk("bubbles", {30'd0, sif.id_exe_bubble, sif.exe_mem_bubble}, {30'd0, e.bub});
      chk("state", {29'd0, sif.muldiv_busy, sif.ctrl_state}, {29'd0, e.busy, e.st});
      chk("stall_cycles", sif.stall_cycles, e.sc);
    end
  end

  initial begin
    stim_t       s;
    logic [31:0] base;

    s = idle();
    rst_n = 1'b0;
    {sif.mem_wait, sif.id_rs_addr, sif.id_rt_addr, sif.id_uses_rs, sif.id_uses_rt,
     sif.exe_is_load, sif.exe_GPR_we, sif.exe_GPR_waddr, sif.exe_muldiv_start,
     sif.exe_muldiv_is_div} = '0;
    repeat (2) @(posedge clk);

    repeat (2) apply(idle(), 1'b0);

    // MULT: 4 stall cycles, DONE, then idle
    base = sif.stall_cycles;
    s = idle(); s.st = 1'b1;
    repeat (MUL_C + 1) apply(s, 1'b0);
    apply(idle(), 1'b0);
    chk("mult_stall_count", sif.stall_cycles - base, 32'd4);

    // Reset held low for 3 cycles in the middle of a DIV
    s = idle(); s.st = 1'b1; s.dv = 1'b1;
    repeat (6) apply(s, 1'b0);
    s.rst_n = 1'b0;
    repeat (3) apply(s, 1'b0);
    apply(idle(), 1'b0);
    chk("reset_clears_count", sif.stall_cycles, 32'd0);

    // DIV with mem_wait pulsed for 3 cycles at BUSY cycle 10
    s = idle(); s.st = 1'b1; s.dv = 1'b1;
    for (int i = 0; i < DIV_C + 1; i++) begin
      s.mw = (i >= 11 && i <= 13);
      apply(s, 1'b0);
    end
    apply(idle(), 1'b0);

    // Load-use: real hazard, then $zero destination, then rs not used
    base = sif.stall_cycles;
    s = idle(); s.ld = 1'b1; s.we = 1'b1; s.wa = 5'd5; s.rs = 5'd5; s.urs = 1'b1;
    apply(s, 1'b0);
    apply(idle(), 1'b0);
    s.wa = 5'd0; s.rs = 5'd0;
    apply(s, 1'b0);
    s.wa = 5'd5; s.rs = 5'd5; s.urs = 1'b0;
    apply(s, 1'b0);
    s.urt = 1'b1; s.rt = 5'd5;
    apply(s, 1'b0);
    apply(idle(), 1'b0);
    chk("load_use_stall_count", sif.stall_cycles - base, 32'd2);

    // Back-to-back DIV then MULT
    base = sif.stall_cycles;
    s = idle(); s.st = 1'b1; s.dv = 1'b1;
    repeat (DIV_C + 1) apply(s, 1'b0);
    s.dv = 1'b0;
    repeat (MUL_C + 1) apply(s, 1'b0);
    apply(idle(), 1'b0);
    chk("b2b_stall_count", sif.stall_cycles - base, 32'd36);

    // Perf counter wrap
    s = idle(); s.ld = 1'b1; s.we = 1'b1; s.wa = 5'd7; s.rt = 5'd7; s.urt = 1'b1;
    apply(s, 1'b1);
    apply(idle(), 1'b0);
    chk("stall_wrap", sif.stall_cycles, 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      s.rst_n = ($urandom_range(0, 99) != 0);
      s.mw    = ($urandom_range(0, 9) == 0);
      s.rs    = 5'($urandom_range(0, 3));
      s.rt    = 5'($urandom_range(0, 3));
      s.urs   = 1'($urandom_range(0, 1));
      s.urt   = 1'($urandom_range(0, 1));
      s.ld    = ($urandom_range(0, 2) == 0);
      s.we    = ($urandom_range(0, 3) != 0);
      s.wa    = 5'($urandom_range(0, 3));
      s.st    = ($urandom_range(0, 9) == 0);
      s.dv    = 1'($urandom_range(0, 1));
      apply(s, 1'b0);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
